// File: rtl/gpio_pixel_capture_pkg.sv
// Shared types for the GPIO pixel capture block: channel geometry, pixel type, FSM states.
package gpio_capture_pkg;
  localparam int CH_W   = 8;
  localparam int DATA_W = 128;
  localparam int LANES  = DATA_W / CH_W;
  localparam int CNT_W  = 16;

  typedef logic [3*CH_W-1:0] pixel_t;
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;
endpackage

// File: rtl/gpio_pixel_capture_if.sv
// GPIO word input plus pixel stream output. The master side is the processor/sink,
// and the slave side is the capture block.
interface gpio_pixel_capture_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] GPIO;
  logic              GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn;
  logic              pix_valid, pix_ready;
  logic [23:0]       pix_data;
  logic              frame_done;
  logic [CNT_W-1:0]  frame_cnt;
  logic              err_ovf, err_partial;

  modport master (
    output GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, pix_ready,
    input  pix_valid, pix_data, frame_done, frame_cnt, err_ovf, err_partial
  );
  modport slave (
    input  GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, pix_ready,
    output pix_valid, pix_data, frame_done, frame_cnt, err_ovf, err_partial
  );
endinterface

// File: rtl/gpio_pixel_capture_edge_detect.sv
// Registered rising-edge detector: a level held high yields a single-cycle rise.
module gpio_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);
  logic [W-1:0] lvl_q;

  always_ff @(posedge clk) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;
endmodule

// File: rtl/gpio_pixel_capture.sv
// Stages R/G/B GPIO words, merges them into 16 RGB888 pixels and streams them out;
// a GPIOEn edge flushes the frame.
module gpio_pixel_capture
  import gpio_capture_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CH_W   = 8,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  gpio_pixel_capture_if.slave  bus
);
  localparam int LANES = DATA_W / CH_W;
  localparam int IDX_W = $clog2(LANES);
  typedef logic [LANES-1:0][CH_W-1:0] word_t;

  // channel index: 0=R 1=G 2=B, rise[3]=GPIOEn
  logic [3:0]       rise;
  word_t            gpio_w;
  word_t            stage_q [3];
  word_t            drain_q [3];
  logic [2:0]       staged;
  logic             drain_full;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] frame_cnt;
  logic             err_ovf, err_partial;
  logic             accept, last, drain_free, commit, partial;
  state_t           st, st_nxt;

  gpio_edge_detect #(.W(4)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .lvl  ({bus.GPIOEn, bus.GPIOEnB, bus.GPIOEnG, bus.GPIOEnR}),
    .rise (rise)
  );

  assign gpio_w     = bus.GPIO;
  assign accept     = drain_full & bus.pix_ready;
  assign last       = accept & (idx == IDX_W'(LANES-1));
  // The final accept frees the drain on the same edge, so the next set loads with no bubble.
  assign drain_free = ~drain_full | last;
  assign commit     = (&staged) & drain_free;
  assign partial    = (st == S_RUN) & rise[3] & (|staged) & ~(&staged);

  always_comb begin
    st_nxt = st;
    case (st)
      S_RUN:   if (rise[3]) st_nxt = S_FLUSH;
      // A complete set still staged must commit and drain before the frame closes.
      S_FLUSH: if (!drain_full && !(|staged)) st_nxt = S_DONE;
      S_DONE:  st_nxt = S_RUN;
      default: st_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_RUN;
      staged      <= '0;
      drain_full  <= 1'b0;
      idx         <= '0;
      frame_cnt   <= '0;
      err_ovf     <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      st <= st_nxt;
      for (int c = 0; c < 3; c++) begin
        if (commit) staged[c] <= 1'b0;
        if (rise[c]) begin
          if (st == S_RUN) begin
            if (staged[c] && !commit) err_ovf   <= 1'b1;
            else                      staged[c] <= 1'b1;
          end else if (st == S_FLUSH) begin
            err_ovf <= 1'b1;
          end
        end
      end
      if (partial) begin
        staged      <= '0;
        err_partial <= 1'b1;
      end
      if (accept) begin
        idx       <= idx + 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (last) drain_full <= 1'b0;
      if (commit) begin
        idx        <= '0;
        drain_full <= 1'b1;
      end
      if (st == S_DONE) frame_cnt <= '0;
    end
  end

  // Data path carries no reset; the staged/drain_full flags qualify it.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (st == S_RUN && rise[c] && (!staged[c] || commit)) stage_q[c] <= gpio_w;
      if (commit) drain_q[c] <= stage_q[c];
    end
  end

  assign bus.pix_valid   = drain_full;
  assign bus.pix_data    = drain_full ? {drain_q[0][idx], drain_q[1][idx], drain_q[2][idx]} : '0;
  assign bus.frame_done  = (st == S_DONE);
  assign bus.frame_cnt   = frame_cnt;
  assign bus.err_ovf     = err_ovf;
  assign bus.err_partial = err_partial;
endmodule

// File: tb/tb_gpio_pixel_capture.sv
// Directed bench for gpio_pixel_capture: pixel merge, stalls, edge detect, errors, flush, reset.
module tb_gpio_pixel_capture;
  import gpio_capture_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  pixel_t got[$];
  int     stamp[$];

  gpio_pixel_capture_if #(.DATA_W(128), .CNT_W(16)) bus ();
  gpio_pixel_capture #(.DATA_W(128), .CH_W(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted pixels, recorded half a cycle ahead of the accepting edge.
  always @(negedge clk)
    if (!rst && bus.pix_valid && bus.pix_ready) begin
      got.push_back(bus.pix_data);
      stamp.push_back(cyc);
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] mk_word(int base);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(base + i);
    return w;
  endfunction

  function automatic pixel_t exp_pix(int i, int rb, int gb, int bb);
    return {8'(rb + i), 8'(gb + i), 8'(bb + i)};
  endfunction

  task automatic send_word(int ch, logic [127:0] data);
    bus.GPIO = data;
    case (ch)
      0: bus.GPIOEnR = 1'b1;
      1: bus.GPIOEnG = 1'b1;
      2: bus.GPIOEnB = 1'b1;
      default: bus.GPIOEn = 1'b1;
    endcase
    step();
    {bus.GPIOEnR, bus.GPIOEnG, bus.GPIOEnB, bus.GPIOEn} = '0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.GPIO = '0;
    {bus.GPIOEnR, bus.GPIOEnG, bus.GPIOEnB, bus.GPIOEn} = '0;
    bus.pix_ready = 1'b0;
    step(); step();
    got.delete(); stamp.delete();
    rst = 1'b0;
  endtask

  task automatic wait_pixels(int n, int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (got.size() >= n) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_done(int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.frame_done) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%0b exp=0", bus.pix_valid); end
    checks++; if (bus.pix_data !== 24'h0) begin failures++; $display("FAIL reset_pix_data got=%h exp=000000", bus.pix_data); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", bus.frame_done); end
    checks++; if (bus.frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", bus.frame_cnt); end
    checks++; if ({bus.err_ovf, bus.err_partial} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b exp=00", {bus.err_ovf, bus.err_partial}); end
  endtask

  task automatic test_basic();
    bit ok; int bad;
    do_reset();
    bus.pix_ready = 1'b1;
    send_word(0, mk_word(8'h00));
    send_word(1, mk_word(8'h10));
    bus.GPIO = mk_word(8'h20); bus.GPIOEnB = 1'b1;
    step();
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%0b exp=0", bus.pix_valid); end
    bus.GPIOEnB = 1'b0;
    step();
    checks++; if (bus.pix_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_load got=%0b exp=1", bus.pix_valid); end
    wait_pixels(16, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=%0d pixels exp=16", got.size()); end
    step();
    checks++; if (got.size() !== 16) begin failures++; $display("FAIL basic_count got=%0d exp=16", got.size()); end
    if (got.size() >= 16) begin
      checks++; if (got[0] !== 24'h001020) begin failures++; $display("FAIL basic_pix0 got=%h exp=001020", got[0]); end
      checks++; if (got[15] !== 24'h0F1F2F) begin failures++; $display("FAIL basic_pix15 got=%h exp=0f1f2f", got[15]); end
      bad = 0;
      for (int i = 0; i < 16; i++) if (got[i] !== exp_pix(i, 'h00, 'h10, 'h20)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL basic_pixels got=%0d wrong exp=0", bad); end
    end
    checks++; if (bus.frame_cnt !== 16'd16) begin failures++; $display("FAIL basic_frame_cnt got=%0d exp=16", bus.frame_cnt); end
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%0b exp=0", bus.pix_valid); end
    send_word(3, '0);
    wait_done(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    checks++; if (bus.frame_cnt !== 16'd16) begin failures++; $display("FAIL basic_cnt_at_done got=%0d exp=16", bus.frame_cnt); end
    step();
    checks++; if ({bus.frame_done, bus.frame_cnt} !== 17'd0) begin failures++; $display("FAIL basic_after_done got=%0b/%0d exp=0/0", bus.frame_done, bus.frame_cnt); end
  endtask

  task automatic test_stall();
    int bad, stalls; logic [23:0] held; bit stalled;
    do_reset();
    send_word(0, mk_word(8'h00));
    send_word(1, mk_word(8'h10));
    send_word(2, mk_word(8'h20));
    bad = 0; stalls = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 100 && got.size() < 16; c++) begin
      if (stalled && (bus.pix_valid !== 1'b1 || bus.pix_data !== held)) bad++;
      bus.pix_ready = c[0];
      stalled = bus.pix_valid && !bus.pix_ready;
      if (stalled) stalls++;
      held = bus.pix_data;
      step();
    end
    checks++; if (bad != 0 || stalls == 0) begin failures++; $display("FAIL stall_hold got=%0d unstable/%0d stalls exp=0/>0", bad, stalls); end
    bad = 0;
    for (int i = 0; i < got.size() && i < 16; i++) if (got[i] !== exp_pix(i, 'h00, 'h10, 'h20)) bad++;
    checks++; if (got.size() !== 16 || bad != 0) begin failures++; $display("FAIL stall_pixels got=%0d pix %0d wrong exp=16 0", got.size(), bad); end
    checks++; if (bus.frame_cnt !== 16'd16) begin failures++; $display("FAIL stall_frame_cnt got=%0d exp=16", bus.frame_cnt); end
  endtask

  task automatic test_level_hold();
    bit ok; int bad;
    do_reset();
    bus.pix_ready = 1'b1;
    bus.GPIO = mk_word(8'h00); bus.GPIOEnR = 1'b1;
    step();
    bus.GPIO = mk_word(8'hA0);
    for (int c = 0; c < 9; c++) step();
    bus.GPIOEnR = 1'b0;
    step();
    send_word(1, mk_word(8'h10));
    send_word(2, mk_word(8'h20));
    wait_pixels(16, 60, ok);
    step(); step();
    checks++; if (bus.err_ovf !== 1'b0) begin failures++; $display("FAIL hold_err_ovf got=%0b exp=0", bus.err_ovf); end
    bad = 0;
    for (int i = 0; i < got.size() && i < 16; i++) if (got[i] !== exp_pix(i, 'h00, 'h10, 'h20)) bad++;
    checks++; if (got.size() !== 16 || bad != 0) begin failures++; $display("FAIL hold_pixels got=%0d pix %0d wrong exp=16 0", got.size(), bad); end
  endtask

  task automatic test_overflow();
    bit ok; int bad;
    do_reset();
    bus.pix_ready = 1'b1;
    send_word(0, mk_word(8'h00));
    send_word(0, mk_word(8'hA0));
    checks++; if (bus.err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bus.err_ovf); end
    send_word(1, mk_word(8'h10));
    send_word(2, mk_word(8'h20));
    wait_pixels(16, 60, ok);
    bad = 0;
    for (int i = 0; i < got.size() && i < 16; i++) if (got[i] !== exp_pix(i, 'h00, 'h10, 'h20)) bad++;
    checks++; if (got.size() !== 16 || bad != 0) begin failures++; $display("FAIL ovf_first_kept got=%0d pix %0d wrong exp=16 0", got.size(), bad); end
  endtask

  task automatic test_partial();
    bit ok;
    do_reset();
    bus.pix_ready = 1'b1;
    send_word(0, mk_word(8'h00));
    send_word(1, mk_word(8'h10));
    send_word(3, '0);
    wait_done(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL partial_done_timeout got=0 exp=1"); end
    checks++; if (bus.err_partial !== 1'b1) begin failures++; $display("FAIL partial_flag got=%0b exp=1", bus.err_partial); end
    checks++; if (got.size() !== 0 || bus.frame_cnt !== 16'd0) begin failures++; $display("FAIL partial_no_pixels got=%0d/%0d exp=0/0", got.size(), bus.frame_cnt); end
    step();
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL partial_pulse_width got=%0b exp=0", bus.frame_done); end
  endtask

  task automatic test_back_to_back();
    bit ok; int bad;
    do_reset();
    bus.pix_ready = 1'b1;
    send_word(0, mk_word(8'h00)); send_word(1, mk_word(8'h10)); send_word(2, mk_word(8'h20));
    send_word(0, mk_word(8'h40)); send_word(1, mk_word(8'h50)); send_word(2, mk_word(8'h60));
    send_word(3, '0);
    wait_done(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done_timeout got=0 exp=1"); end
    checks++; if (got.size() !== 32 || bus.frame_cnt !== 16'd32) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=32/32", got.size(), bus.frame_cnt); end
    if (got.size() == 32) begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (got[i] !== exp_pix(i, 'h00, 'h10, 'h20)) bad++;
        if (got[16+i] !== exp_pix(i, 'h40, 'h50, 'h60)) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_pixels got=%0d wrong exp=0", bad); end
      checks++; if (stamp[31] - stamp[0] != 31) begin failures++; $display("FAIL b2b_contiguous got=%0d cycles exp=31", stamp[31] - stamp[0]); end
    end
    step();
    send_word(0, mk_word(8'h00)); send_word(1, mk_word(8'h10)); send_word(2, mk_word(8'h20));
    wait_pixels(35, 30, ok);
    checks++; if (!ok || bus.pix_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_drain got=%0d/%0b exp=35/1", got.size(), bus.pix_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.pix_valid !== 1'b0 || bus.frame_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_drain got=%0b/%0d exp=0/0", bus.pix_valid, bus.frame_cnt); end
    step();
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL rst_discard got=%0b exp=0", bus.pix_valid); end
  endtask

  initial begin
    bus.GPIO = '0;
    {bus.GPIOEnR, bus.GPIOEnG, bus.GPIOEnB, bus.GPIOEn} = '0;
    bus.pix_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_level_hold();
    test_overflow();
    test_partial();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
